// File: rtl/one_to_two_demux.sv
// ---------------------------------------------------------------------------
// one_to_two_demux
//   Registered 1-to-2 stream demultiplexer. Each input beat is steered to
//   lane 0 or lane 1 by in_select and lands in that lane's 2-entry buffer.
//   Every port uses a valid/ready handshake. There is no combinational path
//   from the input side to the output side.
//
//   Optional feature macro: DEMUX_BEAT_COUNT_EN
//     When it is defined, the CNT_W parameter and the out0_count/out1_count
//     ports exist. Each counter counts the beats delivered on its lane and
//     wraps at 2^CNT_W.
//
// Ports
//   clk, rst            rising-edge clock; asynchronous active-high reset
//   in_data/in_select   input beat payload and lane select (0 -> out0, 1 -> out1)
//   in_valid/in_ready   input handshake; in_ready depends on the selected lane only
//   outN_data/_valid    head of the lane-N buffer
//   outN_ready          lane-N consumer accepts the head beat
//   outN_count          beats delivered on lane N (DEMUX_BEAT_COUNT_EN only)
// ---------------------------------------------------------------------------

// One lane: a 2-entry FIFO with a head register and a tail register.
// The head register drives the output directly. It is only overwritten by
// new data, so it keeps the last popped beat after the lane empties.
module one_to_two_demux_lane #(
    parameter int WIDTH = 8
`ifdef DEMUX_BEAT_COUNT_EN
    ,parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
`ifdef DEMUX_BEAT_COUNT_EN
    output logic [CNT_W-1:0] out_count,
`endif
    output logic             full
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_e;

    occ_e             occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             pop;

    assign out_valid = (occ_q != EMPTY);
    assign out_data  = head_q;
    assign full      = (occ_q == FULL);
    assign pop       = out_valid & out_ready;

    // The top never pushes into a FULL lane (in_ready is low), so the FULL
    // case handles pops only.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case (occ_q)
            EMPTY: begin
                if (push) begin
                    head_d = push_data;
                    occ_d  = ONE;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b10: begin
                        tail_d = push_data;
                        occ_d  = FULL;
                    end
                    2'b01: occ_d = EMPTY;
                    // The head leaves and the new beat replaces it in place.
                    2'b11: head_d = push_data;
                    default: ;
                endcase
            end
            FULL: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = ONE;
                end
            end
            default: occ_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q  <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

`ifdef DEMUX_BEAT_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (pop) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign out_count = count_q;
`endif
endmodule

module one_to_two_demux #(
    parameter int WIDTH = 8
`ifdef DEMUX_BEAT_COUNT_EN
    ,parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_select,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
`ifdef DEMUX_BEAT_COUNT_EN
    output logic [CNT_W-1:0] out0_count,
    output logic [CNT_W-1:0] out1_count,
`endif
    input  logic             out1_ready
);
    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0][WIDTH-1:0] lane_data;
    logic [NUM_LANES-1:0]            lane_valid;
    logic [NUM_LANES-1:0]            lane_ready;
    logic [NUM_LANES-1:0]            lane_full;
    logic [NUM_LANES-1:0]            lane_push;
`ifdef DEMUX_BEAT_COUNT_EN
    logic [NUM_LANES-1:0][CNT_W-1:0] lane_count;
`endif

    // in_ready uses registered occupancy only. A same-cycle pop on a FULL
    // lane does not open it up; the beat goes in on the following cycle.
    assign in_ready = in_select ? ~lane_full[1] : ~lane_full[0];

    assign lane_ready = {out1_ready, out0_ready};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_push[i] = in_valid & in_ready & (in_select == 1'(i));

        one_to_two_demux_lane #(
            .WIDTH (WIDTH)
`ifdef DEMUX_BEAT_COUNT_EN
            ,.CNT_W(CNT_W)
`endif
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .push      (lane_push[i]),
            .push_data (in_data),
            .out_ready (lane_ready[i]),
            .out_data  (lane_data[i]),
            .out_valid (lane_valid[i]),
`ifdef DEMUX_BEAT_COUNT_EN
            .out_count (lane_count[i]),
`endif
            .full      (lane_full[i])
        );
    end

    assign out0_data  = lane_data[0];
    assign out0_valid = lane_valid[0];
    assign out1_data  = lane_data[1];
    assign out1_valid = lane_valid[1];
`ifdef DEMUX_BEAT_COUNT_EN
    assign out0_count = lane_count[0];
    assign out1_count = lane_count[1];
`endif
endmodule

// File: tb/tb_one_to_two_demux.sv
// Directed bench for one_to_two_demux. Inputs change 1 ns after each rising
// edge, and outputs are checked in that same settled window.
module tb_one_to_two_demux;
    localparam int WIDTH = 8;
`ifdef DEMUX_BEAT_COUNT_EN
    localparam int CNT_W = 4;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_select;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data, out1_data;
    logic             out0_valid, out1_valid;
    logic             out0_ready, out1_ready;
`ifdef DEMUX_BEAT_COUNT_EN
    logic [CNT_W-1:0] out0_count, out1_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    one_to_two_demux #(
        .WIDTH(WIDTH)
`ifdef DEMUX_BEAT_COUNT_EN
        ,.CNT_W(CNT_W)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_select  (in_select),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
`ifdef DEMUX_BEAT_COUNT_EN
        .out0_count (out0_count),
        .out1_count (out1_count),
`endif
        .out1_ready (out1_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_select = 1'b0; in_valid = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        step(); step();
        chk("rst_out0_valid", 32'(out0_valid), 0);
        chk("rst_out1_valid", 32'(out1_valid), 0);
        chk("rst_out0_data",  32'(out0_data), 0);
        chk("rst_out1_data",  32'(out1_data), 0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        // Single beat to lane 0, visible one cycle after it is accepted
        in_data = 8'hA5; in_select = 1'b0; in_valid = 1'b1; out0_ready = 1'b1;
        #1 chk("t2_in_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("t2_out0_valid", 32'(out0_valid), 1);
        chk("t2_out0_data",  32'(out0_data), 32'hA5);
        chk("t2_out1_valid", 32'(out1_valid), 0);
        step();
        chk("t2_popped_valid", 32'(out0_valid), 0);
        chk("t2_data_held",    32'(out0_data), 32'hA5);

        // Fill lane 1 while it is stalled; lane 0 stays open
        out1_ready = 1'b0; in_select = 1'b1; in_valid = 1'b1;
        in_data = 8'h11; step();
        in_data = 8'h22; step();
        in_valid = 1'b0;
        #1 chk("t3_ready_sel1", 32'(in_ready), 0);
        in_select = 1'b0;
        #1 chk("t3_ready_sel0", 32'(in_ready), 1);
        chk("t3_head", 32'(out1_data), 32'h11);
        chk("t3_out0_idle", 32'(out0_valid), 0);
        out1_ready = 1'b1;
        step();
        chk("t3_second_valid", 32'(out1_valid), 1);
        chk("t3_second_data",  32'(out1_data), 32'h22);
        step();
        chk("t3_drained", 32'(out1_valid), 0);

        // Lane 0 is FULL and pops in the same cycle as a new beat arrives
        out0_ready = 1'b0; in_select = 1'b0; in_valid = 1'b1;
        in_data = 8'h31; step();
        in_data = 8'h32; step();
        in_data = 8'h33; out0_ready = 1'b1;
        #1 chk("t4_full_not_ready", 32'(in_ready), 0);
        step();
        chk("t4_head_after_pop", 32'(out0_data), 32'h32);
        chk("t4_ready_again", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("t4_accepted_valid", 32'(out0_valid), 1);
        chk("t4_accepted_data",  32'(out0_data), 32'h33);
        step();
        chk("t4_empty", 32'(out0_valid), 0);
        chk("t4_no_dup_hold", 32'(out0_data), 32'h33);

        // Alternating selects at one beat per cycle with both consumers ready
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 8'(i); in_select = 1'((i - 1) % 2); in_valid = 1'b1;
            #1 chk("t5_in_ready", 32'(in_ready), 1);
            step();
            if (i % 2 == 1) begin
                chk("t5_lane0_valid", 32'(out0_valid), 1);
                chk("t5_lane0_data",  32'(out0_data), 32'(i));
                chk("t5_lane1_idle",  32'(out1_valid), 0);
            end else begin
                chk("t5_lane1_valid", 32'(out1_valid), 1);
                chk("t5_lane1_data",  32'(out1_data), 32'(i));
                chk("t5_lane0_idle",  32'(out0_valid), 0);
            end
        end
        in_valid = 1'b0;
        step();
        chk("t5_end_lane0", 32'(out0_valid), 0);
        chk("t5_end_lane1", 32'(out1_valid), 0);

        // Reset pulse in the middle of a stream with two beats buffered in lane 0
        out0_ready = 1'b0; in_select = 1'b0; in_valid = 1'b1;
        in_data = 8'h41; step();
        in_data = 8'h42; step();
        in_valid = 1'b0;
        chk("t1_pre_full", 32'(in_ready), 0);
        rst = 1'b1;
        step();
        chk("t1_valid_cleared", 32'(out0_valid), 0);
        chk("t1_data_cleared",  32'(out0_data), 0);
        rst = 1'b0;
        #1 chk("t1_in_ready", 32'(in_ready), 1);

`ifdef DEMUX_BEAT_COUNT_EN
        chk("t6_count0_reset", 32'(out0_count), 0);
        chk("t6_count1_reset", 32'(out1_count), 0);
        // 17 beats through lane 0; the counter wraps at 16
        out0_ready = 1'b1; in_select = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 8'(8'h60 + i);
            step();
            chk("t6_stream_data", 32'(out0_data), 32'(8'h60 + i));
        end
        in_valid = 1'b0;
        step();
        chk("t6_count0_wrap", 32'(out0_count), 1);
        chk("t6_count1_zero", 32'(out1_count), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
